// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter stage of the MIPS fetch path. Holds the PC register and picks
// the next PC from the sequential increment, a branch target or a jump target.
// Supports hazard stalls, halting on a decoded HALT and debug run/step control.
//
// Ports
//   i_clk          system clock, state updates on rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       debug unit: 1 = core may run, 0 = full freeze
//   i_step_mode    1 = advance only on i_step, 0 = free run
//   i_step         one-cycle pulse allowing one PC update in step mode
//   i_stall        hazard unit: hold PC this cycle
//   i_branch       take i_branch_addr this cycle (highest priority)
//   i_branch_addr  branch target, low two bits ignored
//   i_jump         take i_jump_addr this cycle
//   i_jump_addr    jump target, low two bits ignored
//   i_halt         HALT decoded; stop instead of updating
//   o_pc           current PC (registered)
//   o_pc_plus4     o_pc + PC_INC, combinational, wraps modulo 2^PC_SIZE
//   o_advance      1 = PC updates at next edge (combinational)
//   o_halted       1 = unit is halted (registered)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned              PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0]       PC_INC   = PC_SIZE'(4),
  parameter logic [PC_SIZE-1:0]       RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_branch,
  input  logic [PC_SIZE-1:0] i_branch_addr,
  input  logic               i_jump,
  input  logic [PC_SIZE-1:0] i_jump_addr,
  input  logic               i_halt,
  output logic [PC_SIZE-1:0] o_pc,
  output logic [PC_SIZE-1:0] o_pc_plus4,
  output logic               o_advance,
  output logic               o_halted
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_STEP = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  // Redirect targets are word aligned: clear the two byte-offset bits.
  localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~(PC_SIZE'(3));

  state_t             state_r;
  state_t             next_state_s;
  logic [PC_SIZE-1:0] pc_r;
  logic [PC_SIZE-1:0] next_pc_s;
  logic [PC_SIZE-1:0] pc_plus_inc_s;
  logic               halted_r;
  logic               allowed_s;
  logic               advance_s;

  assign pc_plus_inc_s = pc_r + PC_INC;

  // Run/step permission, next state and next PC selection.
  always_comb begin
    allowed_s    = 1'b0;
    next_state_s = state_r;
    next_pc_s    = pc_plus_inc_s;

    case (state_r)
      ST_RUN: begin
        // Entering step mode costs one cycle with no update.
        if (i_step_mode) begin
          allowed_s    = 1'b0;
          next_state_s = ST_WAIT_STEP;
        end else begin
          allowed_s    = 1'b1;
          next_state_s = ST_RUN;
        end
      end
      ST_WAIT_STEP: begin
        // A held i_step gives one update per cycle it is high.
        allowed_s = i_step;
        if (i_step_mode) begin
          next_state_s = ST_WAIT_STEP;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        allowed_s    = 1'b0;
        next_state_s = ST_HALTED;
      end
      default: begin
        allowed_s    = 1'b0;
        next_state_s = ST_RUN;
      end
    endcase

    advance_s = allowed_s & i_enable & ~i_stall & ~i_reset
              & (state_r != ST_HALTED);

    // A HALT only takes effect in a cycle that would otherwise advance.
    if (advance_s && i_halt) begin
      next_state_s = ST_HALTED;
    end else begin
      next_state_s = next_state_s;
    end

    if (i_branch) begin
      next_pc_s = i_branch_addr & ALIGN_MASK;
    end else if (i_jump) begin
      next_pc_s = i_jump_addr & ALIGN_MASK;
    end else begin
      next_pc_s = pc_plus_inc_s;
    end
  end

  // PC register and control state; disabled or halted means nothing moves.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_r     <= RESET_PC;
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else if (i_enable && (state_r != ST_HALTED)) begin
      state_r  <= next_state_s;
      halted_r <= advance_s & i_halt;
      if (advance_s && !i_halt) begin
        pc_r <= next_pc_s;
      end
    end
  end

  assign o_pc       = pc_r;
  assign o_pc_plus4 = pc_plus_inc_s;
  assign o_advance  = advance_s;
  assign o_halted   = halted_r;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_step_mode;
  logic        i_step;
  logic        i_stall;
  logic        i_branch;
  logic [31:0] i_branch_addr;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_halt;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_advance;
  logic        o_halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC value, halted flag, and whether the step-mode request
  // seen at the last enabled edge is in force (step mode takes one cycle).
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_stepping;

  pc_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_step_mode(i_step_mode), .i_step(i_step), .i_stall(i_stall),
    .i_branch(i_branch), .i_branch_addr(i_branch_addr),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_halt(i_halt),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_advance(o_advance),
    .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_moves();
    if (i_reset || m_halted || !i_enable || i_stall) return 1'b0;
    if (m_stepping) return i_step;
    return !i_step_mode;
  endfunction

  function automatic logic [31:0] model_target();
    if (i_branch) return {i_branch_addr[31:2], 2'b00};
    if (i_jump)   return {i_jump_addr[31:2], 2'b00};
    return m_pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    i_enable = 1'b1; i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_branch = 1'b0; i_jump = 1'b0; i_halt = 1'b0;
    i_branch_addr = 32'd0; i_jump_addr = 32'd0;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered ones.
  task automatic cycle();
    bit          mv;
    logic [31:0] tgt;
    if (i_reset) begin
      m_pc = 32'd0; m_halted = 1'b0; m_stepping = 1'b0;
    end
    @(negedge i_clk);
    mv  = model_moves();
    tgt = model_target();
    check_value("advance", {31'd0, o_advance}, {31'd0, mv});
    check_value("pc_plus4", o_pc_plus4, m_pc + 32'd4);
    @(posedge i_clk);
    if (!i_reset && !m_halted && i_enable) begin
      m_stepping = i_step_mode;
      if (mv) begin
        if (i_halt) m_halted = 1'b1;
        else        m_pc = tgt;
      end
    end
    #1;
    check_value("pc", o_pc, m_pc);
    check_value("halted", {31'd0, o_halted}, {31'd0, m_halted});
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    m_pc = 32'd0; m_halted = 1'b0; m_stepping = 1'b0;
    check_value("async_rst_pc", o_pc, 32'd0);
    check_value("async_rst_halted", {31'd0, o_halted}, 32'd0);
    check_value("async_rst_adv", {31'd0, o_advance}, 32'd0);
    cycle();
    i_reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    m_pc = 32'd0; m_halted = 1'b0; m_stepping = 1'b0;
    @(posedge i_clk); #1;
    do_reset();

    // Free run from reset.
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check_value("t1_seq", o_pc, 32'(4 * k));
    end

    // Branch beats jump; target low bits cleared.
    do_reset();
    cycle(); cycle();
    check_value("t2_at8", o_pc, 32'h8);
    i_branch = 1'b1; i_branch_addr = 32'h40; i_jump = 1'b1; i_jump_addr = 32'h80;
    cycle();
    check_value("t2_branch", o_pc, 32'h40);
    i_jump = 1'b0; i_branch_addr = 32'h43;
    cycle();
    check_value("t2_align", o_pc, 32'h40);

    // Stall wins over branch.
    i_branch = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h10;
    cycle();
    i_jump = 1'b0; i_stall = 1'b1; i_branch = 1'b1; i_branch_addr = 32'h100;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check_value("t3_hold", o_pc, 32'h10);
    end
    i_stall = 1'b0; i_branch = 1'b0;
    cycle();
    check_value("t3_resume", o_pc, 32'h14);

    // Step mode: pulses in cycles 3 and 7.
    do_reset();
    i_step_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_step = (c == 3 || c == 7);
      cycle();
      check_value("t4_step", o_pc, (c < 3) ? 32'd0 : ((c < 7) ? 32'd4 : 32'd8));
    end
    idle_inputs();

    // Halt freezes the PC until reset.
    do_reset();
    i_jump = 1'b1; i_jump_addr = 32'h20;
    cycle();
    i_jump = 1'b0; i_halt = 1'b1;
    cycle();
    check_value("t5_halted", {31'd0, o_halted}, 32'd1);
    check_value("t5_pc", o_pc, 32'h20);
    i_halt = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h80;
    cycle(); cycle();
    check_value("t5_frozen", o_pc, 32'h20);
    i_jump = 1'b0;
    do_reset();
    cycle();
    check_value("t5_rerun", o_pc, 32'h4);

    // Wrap at the top of the address space, then async reset mid-cycle.
    i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
    cycle();
    i_jump = 1'b0;
    cycle();
    check_value("t6_wrap", o_pc, 32'h0);
    cycle();
    #3;
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      i_reset       = (($urandom % 80) == 0) || (m_halted && (($urandom % 6) == 0));
      i_enable      = ($urandom % 8) != 0;
      if (($urandom % 15) == 0) i_step_mode = ~i_step_mode;
      i_step        = ($urandom % 3) == 0;
      i_stall       = ($urandom % 5) == 0;
      i_branch      = ($urandom % 4) == 0;
      i_jump        = ($urandom % 4) == 0;
      i_branch_addr = $urandom;
      i_jump_addr   = $urandom;
      i_halt        = ($urandom % 30) == 0;
      cycle();
    end
    i_reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
